cursor_frame_sched: RTL

//  Schedules the cursor position fed to the mouse overlay stage (x_start/y_start of the draw_mouse stage).

---
 rtl/vga_pkg.sv | 36 +++
 rtl/cursor_sat_add.sv | 26 ++
 rtl/cursor_frame_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry, cursor-scheduler enums and the keypad accumulator helper.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  // Keypad accumulators are 13 b signed and saturate symmetrically.
  localparam int ACC_W   = 13;
  localparam int ACC_MAX = 4095;

  typedef enum logic {
    SRC_MOUSE = 1'b0,
    SRC_KEY   = 1'b1
  } cursor_src_t;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    COMMIT = 2'd1,
    BLANK  = 2'd2
  } sched_state_t;

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [7:0]       step
  );
    logic signed [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-7){step[7]}}, step};
    if (sum > (ACC_W+1)'(ACC_MAX))
      return ACC_W'(ACC_MAX);
    else if (sum < -(ACC_W+1)'(ACC_MAX))
      return -ACC_W'(ACC_MAX);
    else
      return sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/cursor_sat_add.sv
// Adds a signed keypad delta to an unsigned coordinate and clamps to [0, LIMIT-1].
module cursor_sat_add
  import vga_pkg::*;
#(
  parameter int LIMIT = HOR_PIXELS
) (
  input  logic        [11:0]      base,
  input  logic signed [ACC_W-1:0] delta,
  output logic        [11:0]      result
);

  localparam logic signed [ACC_W:0] MAX_S = (ACC_W+1)'(LIMIT - 1);

  logic signed [ACC_W:0] sum;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    sum    = $signed({2'b00, base}) + $signed({delta[ACC_W-1], delta});
    result = sum[11:0];
    if (sum < 0)
      result = '0;
    else if (sum > MAX_S)
      result = MAX_S[11:0];
  end

endmodule

// File: rtl/cursor_frame_sched.sv
// Per-frame cursor scheduler: collects mouse/keypad requests and commits one winner at vblnk rise.
module cursor_frame_sched
  import vga_pkg::*;
#(
  parameter int H_PIX       = HOR_PIXELS,
  parameter int V_PIX       = VER_PIXELS,
  parameter int IDLE_FRAMES = 300
) (
  input  logic               clk40MHz,
  input  logic               rst,
  input  logic               vblnk,
  input  logic               m_valid,
  input  logic        [11:0] m_xpos,
  input  logic        [11:0] m_ypos,
  input  logic               k_valid,
  input  logic signed [7:0]  k_dx,
  input  logic signed [7:0]  k_dy,
  output logic        [11:0] x_start,
  output logic        [11:0] y_start,
  output logic               cursor_en,
  output logic               src_last,
  output logic               commit_tick
);

  localparam int IDLE_W = (IDLE_FRAMES < 1) ? 1 : $clog2(IDLE_FRAMES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_FRAMES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = (IDLE_FRAMES == 0) ? '0 : IDLE_W'(IDLE_FRAMES - 1);
  localparam logic [11:0] X_MAX = 12'(H_PIX - 1);
  localparam logic [11:0] Y_MAX = 12'(V_PIX - 1);

  sched_state_t state_q, state_d;
  cursor_src_t  src_q;

  logic                    vblnk_q;
  logic                    m_pend, k_pend;
  logic [11:0]             m_x, m_y;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic signed [ACC_W-1:0] acc_x_base, acc_y_base;
  logic [IDLE_W-1:0]       idle_cnt;
  logic [11:0]             key_x, key_y;
  logic                    in_commit;

  assign in_commit = (state_q == COMMIT);
  assign src_last  = src_q;

  cursor_sat_add #(.LIMIT(H_PIX)) u_sat_x (
    .base   (x_start),
    .delta  (acc_x),
    .result (key_x)
  );

  cursor_sat_add #(.LIMIT(V_PIX)) u_sat_y (
    .base   (y_start),
    .delta  (acc_y),
    .result (key_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE:  if (vblnk && !vblnk_q) state_d = COMMIT;
      COMMIT:  state_d = BLANK;
      BLANK:   if (!vblnk) state_d = ACTIVE;
      default: state_d = BLANK;
    endcase
  end

  // The commit consumes (or drops) the accumulators, so a step arriving that cycle starts from zero.
  always_comb begin
    acc_x_base = in_commit ? '0 : acc_x;
    acc_y_base = in_commit ? '0 : acc_y;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      // Resetting into BLANK means a vblnk already high at reset release must fall and rise again.
      state_q     <= BLANK;
      vblnk_q     <= 1'b0;
      m_pend      <= 1'b0;
      k_pend      <= 1'b0;
      m_x         <= '0;
      m_y         <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      idle_cnt    <= '0;
      x_start     <= 12'(H_PIX / 2);
      y_start     <= 12'(V_PIX / 2);
      cursor_en   <= 1'b1;
      src_q       <= SRC_MOUSE;
      commit_tick <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblnk_q     <= vblnk;
      commit_tick <= 1'b0;

      m_pend <= m_valid | (m_pend & ~in_commit);
      if (m_valid) begin
        m_x <= m_xpos;
        m_y <= m_ypos;
      end

      k_pend <= k_valid | (k_pend & ~in_commit);
      acc_x  <= k_valid ? acc_add(acc_x_base, k_dx) : acc_x_base;
      acc_y  <= k_valid ? acc_add(acc_y_base, k_dy) : acc_y_base;

      if (in_commit) begin
        if (m_pend || k_pend) begin
          commit_tick <= 1'b1;
          cursor_en   <= 1'b1;
          idle_cnt    <= '0;
          if (m_pend) begin
            x_start <= (m_x > X_MAX) ? X_MAX : m_x;
            y_start <= (m_y > Y_MAX) ? Y_MAX : m_y;
            src_q   <= SRC_MOUSE;
          end else begin
            x_start <= key_x;
            y_start <= key_y;
            src_q   <= SRC_KEY;
          end
        end else begin
          if (idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;
          if (IDLE_FRAMES != 0 && idle_cnt >= IDLE_LAST)
            cursor_en <= 1'b0;
        end
      end
    end
  end

endmodule
